// File: rtl/prog_delay_pkg.sv
// ============================================================================
// prog_delay_pkg : shared types and helpers for the programmable delay line
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package prog_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  function automatic int unsigned dly_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned sel, input int unsigned max);
    return (sel > max) ? max : sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_delay_line_stage.sv
// ============================================================================
// delay_stage : one {valid, data} pipeline register with advance enable and
//               a valid-only clear used to flush the pipeline on reload.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module delay_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_valid_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Clearing drops only the valid bit; stale data is masked at the output tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_valid_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/prog_delay_line.sv
// ============================================================================
// prog_delay_line : run-time programmable delay (0..MAX_DELAY enabled cycles)
//                   for a WIDTH-bit bus with per-sample valid.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 4,
  parameter int DLY_W         = dly_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_sel,
  input  logic [DLY_W-1:0] delay_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed,
  output logic [DLY_W-1:0] cur_delay
);

  localparam logic [DLY_W-1:0] DEFAULT_SEL = DLY_W'(DEFAULT_DELAY);
  localparam fsm_state_e       RESET_STATE = (DEFAULT_DELAY == 0) ? RUN : FILL;

  logic [MAX_DELAY-1:0] stage_valid;
  logic [WIDTH-1:0]     stage_data [MAX_DELAY];

  logic [DLY_W-1:0] cur_delay_q, cur_delay_d;
  logic [DLY_W-1:0] fill_cnt_q, fill_cnt_d;
  fsm_state_e       state_q, state_d;
  logic [DLY_W-1:0] sel_clamped;
  logic [DLY_W-1:0] fill_cnt_inc;
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;

  for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             clr;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
      // A sample written in the reload cycle becomes the first of the new pipeline.
      assign clr       = load_sel & ~en;
    end else begin : g_tail
      assign src_valid = stage_valid[k-1];
      assign src_data  = stage_data[k-1];
      assign clr       = load_sel;
    end

    delay_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en),
      .clear_valid_i(clr),
      .valid_i      (src_valid),
      .data_i       (src_data),
      .valid_o      (stage_valid[k]),
      .data_o       (stage_data[k])
    );
  end

  assign sel_clamped = DLY_W'(clamp_delay(32'(delay_sel), MAX_DELAY));

  always_comb begin
    cur_delay_d = cur_delay_q;
    if (load_sel) begin
      cur_delay_d = sel_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_delay_q <= DEFAULT_SEL;
      state_q     <= RESET_STATE;
      fill_cnt_q  <= '0;
    end else begin
      cur_delay_q <= cur_delay_d;
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
    end
  end

  assign fill_cnt_inc = (fill_cnt_q == {DLY_W{1'b1}}) ? fill_cnt_q : fill_cnt_q + DLY_W'(1);

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (load_sel) begin
      state_d    = FILL;
      fill_cnt_d = en ? DLY_W'(1) : '0;
    end else begin
      case (state_q)
        FILL: begin
          // Already full (reload with en, or zero delay): go on the next edge.
          if (fill_cnt_q >= cur_delay_q) begin
            state_d = RUN;
          end else if (en) begin
            fill_cnt_d = fill_cnt_inc;
            if (fill_cnt_inc >= cur_delay_q) begin
              state_d = RUN;
            end
          end
        end
        RUN:     state_d = RUN;
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    if (cur_delay_q == '0) begin
      tap_valid = in_valid;
      tap_data  = in_data;
    end else begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        if (cur_delay_q == DLY_W'(k + 1)) begin
          tap_valid = stage_valid[k];
          tap_data  = stage_data[k];
        end
      end
    end
  end

  assign out_valid = tap_valid;
  assign out_data  = tap_valid ? tap_data : '0;
  assign primed    = (state_q == RUN);
  assign cur_delay = cur_delay_q;

endmodule

`default_nettype wire
